if_stage: RTL and testbench

//  Instruction-fetch stage of the 5-stage LoongArch pipeline: the producer of fs_to_ds_bus and consumer of br_bus.

---
 rtl/if_stage_pkg.sv | 27 ++
 rtl/if_inst_buf.sv | 43 ++++
 rtl/if_stage.sv | 158 +++++++++++++++
 tb/tb_if_stage.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/if_stage_pkg.sv
// Shared fetch-stage types and widths: fetch-to-decode bus layout, branch bus layout, reset PC.
// Imported by if_stage and its inst buffer.
package if_stage_pkg;

  localparam logic [31:0] IF_RESET_PC     = 32'h1c00_0000;
  localparam int          FS_TO_DS_BUS_WD = 64;
  localparam int          BR_BUS_WD       = 33;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } fs_to_ds_t;

  typedef struct packed {
    logic        taken;
    logic [31:0] target;
  } br_t;

  function automatic logic [31:0] seq_pc(input logic [31:0] pc);
    return pc + 32'd4;
  endfunction

  function automatic logic pc_misaligned(input logic [31:0] pc);
    return pc[1:0] != 2'b00;
  endfunction

endpackage

// File: rtl/if_inst_buf.sv
// One-entry hold register for an instruction returned while decode is stalled.
// Latency: data visible the cycle after load; clear has priority over load.
// Backpressure: none of its own, the owner decides when to load and clear.
module if_inst_buf #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         resetn,
  input  logic         load,
  input  logic         clear,
  input  logic [W-1:0] din,
  output logic         valid,
  output logic [W-1:0] data
);

  logic         valid_q, valid_d;
  logic [W-1:0] data_q, data_d;

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (clear) begin
      valid_d = 1'b0;
    end else if (load) begin
      valid_d = 1'b1;
      data_d  = din;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign valid = valid_q;
  assign data  = data_q;

endmodule

// File: rtl/if_stage.sv
// Instruction fetch: pre-IF PC, SRAM-like fetch port (1 outstanding), stall buffer, branch squash.
// Latency: entry offered to decode in the data_ok cycle; back-to-back issue when decode keeps up.
// Backpressure: ds_allowin low holds the entry (buffered) and blocks new requests. IF_ADEF_CHECK_EN adds fs_adef.
module if_stage
  import if_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC = IF_RESET_PC
) (
  input  logic                       clk,
  input  logic                       resetn,
  input  logic                       ds_allowin,
  input  logic [BR_BUS_WD-1:0]       br_bus,
  output logic                       fs_to_ds_valid,
  output logic [FS_TO_DS_BUS_WD-1:0] fs_to_ds_bus,
`ifdef IF_ADEF_CHECK_EN
  output logic                       fs_adef,
`endif
  output logic                       inst_sram_req,
  output logic                       inst_sram_wr,
  output logic [1:0]                 inst_sram_size,
  output logic [31:0]                inst_sram_addr,
  input  logic                       inst_sram_addr_ok,
  input  logic                       inst_sram_data_ok,
  input  logic [31:0]                inst_sram_rdata
);

  br_t         br;
  fs_to_ds_t   bus_s;

  logic [31:0] pf_pc_q, pf_pc_d;
  logic [31:0] fs_pc_q, fs_pc_d;
  logic        fs_valid_q, fs_valid_d;
  logic        cancel_q, cancel_d;
  logic        started_q, started_d;

  logic        buf_valid, buf_load, buf_clear;
  logic [31:0] buf_inst;

  logic        data_ok_live, fs_ready_go, fs_allowin;
  logic        fetch_ok, addr_hs, new_entry, ds_accept;
  logic [31:0] fs_inst;

`ifdef IF_ADEF_CHECK_EN
  logic        adef_q, adef_d, adef_fetch;
`endif

  assign br = br_t'(br_bus);

  always_comb begin
    // A response arriving while cancel is set belongs to a squashed fetch.
    data_ok_live = inst_sram_data_ok & ~cancel_q;
`ifdef IF_ADEF_CHECK_EN
    fs_ready_go  = buf_valid | data_ok_live | adef_q;
`else
    fs_ready_go  = buf_valid | data_ok_live;
`endif
    fs_allowin     = ~fs_valid_q | (fs_ready_go & ds_allowin);
    fs_to_ds_valid = fs_valid_q & fs_ready_go & ~br.taken;
    ds_accept      = fs_valid_q & fs_ready_go & ds_allowin;
    fetch_ok       = started_q & fs_allowin & ~cancel_q & ~br.taken;
`ifdef IF_ADEF_CHECK_EN
    inst_sram_req  = fetch_ok & ~pc_misaligned(pf_pc_q);
    adef_fetch     = fetch_ok & pc_misaligned(pf_pc_q);
`else
    inst_sram_req  = fetch_ok;
`endif
    addr_hs        = inst_sram_req & inst_sram_addr_ok;
`ifdef IF_ADEF_CHECK_EN
    new_entry      = addr_hs | adef_fetch;
`else
    new_entry      = addr_hs;
`endif

    fs_valid_d = fs_valid_q;
    if (br.taken) begin
      fs_valid_d = 1'b0;
    end else if (new_entry) begin
      fs_valid_d = 1'b1;
    end else if (ds_accept) begin
      fs_valid_d = 1'b0;
    end

    fs_pc_d = new_entry ? pf_pc_q : fs_pc_q;

    pf_pc_d = pf_pc_q;
    if (br.taken) begin
      pf_pc_d = br.target;
    end else if (addr_hs) begin
      pf_pc_d = seq_pc(pf_pc_q);
    end

    // Branch with the response still in flight: drop that response when it lands.
    cancel_d = cancel_q;
    if (cancel_q && inst_sram_data_ok) begin
      cancel_d = 1'b0;
    end else if (br.taken && fs_valid_q && !fs_ready_go) begin
      cancel_d = 1'b1;
    end

    started_d = 1'b1;

    buf_load  = fs_valid_q & data_ok_live & ~ds_allowin & ~br.taken & ~buf_valid;
    buf_clear = br.taken | ds_accept;

`ifdef IF_ADEF_CHECK_EN
    adef_d  = adef_fetch | (adef_q & fs_valid_d & ~addr_hs);
    fs_inst = adef_q ? 32'h0 : (buf_valid ? buf_inst : inst_sram_rdata);
`else
    fs_inst = buf_valid ? buf_inst : inst_sram_rdata;
`endif
    bus_s.pc   = fs_pc_q;
    bus_s.inst = fs_inst;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      pf_pc_q    <= RESET_PC;
      fs_pc_q    <= '0;
      fs_valid_q <= 1'b0;
      cancel_q   <= 1'b0;
      started_q  <= 1'b0;
    end else begin
      pf_pc_q    <= pf_pc_d;
      fs_pc_q    <= fs_pc_d;
      fs_valid_q <= fs_valid_d;
      cancel_q   <= cancel_d;
      started_q  <= started_d;
    end
  end

`ifdef IF_ADEF_CHECK_EN
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      adef_q <= 1'b0;
    end else begin
      adef_q <= adef_d;
    end
  end

  assign fs_adef = fs_to_ds_valid & adef_q;
`endif

  if_inst_buf #(.W(32)) u_inst_buf (
    .clk    (clk),
    .resetn (resetn),
    .load   (buf_load),
    .clear  (buf_clear),
    .din    (inst_sram_rdata),
    .valid  (buf_valid),
    .data   (buf_inst)
  );

  assign fs_to_ds_bus   = fs_valid_q ? FS_TO_DS_BUS_WD'(bus_s) : '0;
  assign inst_sram_wr   = 1'b0;
  assign inst_sram_size = 2'b10;
  assign inst_sram_addr = pf_pc_q;

endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage: reset, sequential fetch, decode stall, branch squash, mid-run reset.
module tb_if_stage;
  import if_stage_pkg::*;

  logic        clk = 1'b0;
  logic        resetn;
  logic        ds_allowin;
  logic [32:0] br_bus;
  logic        fs_to_ds_valid;
  logic [63:0] fs_to_ds_bus;
  logic        inst_sram_req;
  logic        inst_sram_wr;
  logic [1:0]  inst_sram_size;
  logic [31:0] inst_sram_addr;
  logic        addr_ok;
  logic        data_ok;
  logic [31:0] rdata;
`ifdef IF_ADEF_CHECK_EN
  logic        fs_adef;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  if_stage dut (
    .clk               (clk),
    .resetn            (resetn),
    .ds_allowin        (ds_allowin),
    .br_bus            (br_bus),
    .fs_to_ds_valid    (fs_to_ds_valid),
    .fs_to_ds_bus      (fs_to_ds_bus),
`ifdef IF_ADEF_CHECK_EN
    .fs_adef           (fs_adef),
`endif
    .inst_sram_req     (inst_sram_req),
    .inst_sram_wr      (inst_sram_wr),
    .inst_sram_size    (inst_sram_size),
    .inst_sram_addr    (inst_sram_addr),
    .inst_sram_addr_ok (addr_ok),
    .inst_sram_data_ok (data_ok),
    .inst_sram_rdata   (rdata)
  );

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    ds_allowin = 1'b1;
    br_bus     = '0;
    addr_ok    = 1'b0;
    data_ok    = 1'b0;
    rdata      = '0;
  endtask

  // Leaves the bench at a negedge where started is already set.
  task automatic do_reset();
    resetn = 1'b0;
    idle_inputs();
    tick();
    resetn = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    idle_inputs();
    data_ok = 1'b1;
    rdata   = 32'hdead_beef;
    tick();
    #1;
    checks++; if (inst_sram_req !== 1'b0) begin errors++; $display("FAIL rst_req got=%b exp=0", inst_sram_req); end
    checks++; if (fs_to_ds_valid !== 1'b0) begin errors++; $display("FAIL rst_valid got=%b exp=0", fs_to_ds_valid); end
    checks++; if (fs_to_ds_bus !== 64'h0) begin errors++; $display("FAIL rst_bus got=%h exp=0", fs_to_ds_bus); end
    checks++; if (inst_sram_addr !== 32'h1c00_0000) begin errors++; $display("FAIL rst_addr got=%h exp=1c000000", inst_sram_addr); end
    checks++; if (inst_sram_wr !== 1'b0 || inst_sram_size !== 2'b10) begin errors++; $display("FAIL rst_wr_size got=%b/%b exp=0/10", inst_sram_wr, inst_sram_size); end
    tick();
    idle_inputs();
    resetn = 1'b1;
    #1;
    checks++; if (inst_sram_req !== 1'b0) begin errors++; $display("FAIL rst_release_req got=%b exp=0", inst_sram_req); end
    tick();
    #1;
    checks++; if (inst_sram_req !== 1'b1) begin errors++; $display("FAIL rst_first_req got=%b exp=1", inst_sram_req); end
  endtask

  task automatic test_sequential();
    do_reset();
    addr_ok = 1'b1;
    #1;
    checks++; if (inst_sram_req !== 1'b1 || inst_sram_addr !== 32'h1c00_0000) begin errors++; $display("FAIL seq_a0 got=%b/%h exp=1/1c000000", inst_sram_req, inst_sram_addr); end
    tick();
    data_ok = 1'b1; rdata = 32'h1111_0000;
    #1;
    checks++; if (fs_to_ds_valid !== 1'b1 || fs_to_ds_bus !== 64'h1c00_0000_1111_0000) begin errors++; $display("FAIL seq_e0 got=%b/%h exp=1/1c000000_11110000", fs_to_ds_valid, fs_to_ds_bus); end
    checks++; if (inst_sram_req !== 1'b1 || inst_sram_addr !== 32'h1c00_0004) begin errors++; $display("FAIL seq_a1 got=%b/%h exp=1/1c000004", inst_sram_req, inst_sram_addr); end
    tick();
    addr_ok = 1'b0; data_ok = 1'b1; rdata = 32'h2222_0004;
    #1;
    checks++; if (fs_to_ds_valid !== 1'b1 || fs_to_ds_bus !== 64'h1c00_0004_2222_0004) begin errors++; $display("FAIL seq_e1 got=%b/%h exp=1/1c000004_22220004", fs_to_ds_valid, fs_to_ds_bus); end
    checks++; if (inst_sram_addr !== 32'h1c00_0008) begin errors++; $display("FAIL seq_a2 got=%h exp=1c000008", inst_sram_addr); end
    tick();
    data_ok = 1'b0;
    #1;
    checks++; if (fs_to_ds_valid !== 1'b0 || inst_sram_req !== 1'b1) begin errors++; $display("FAIL seq_drain got=%b/%b exp=0/1", fs_to_ds_valid, inst_sram_req); end
  endtask

  task automatic test_stall();
    do_reset();
    addr_ok = 1'b1;
    tick();
    ds_allowin = 1'b0; data_ok = 1'b1; rdata = 32'h0280_0421;
    #1;
    checks++; if (inst_sram_req !== 1'b0) begin errors++; $display("FAIL stall_req0 got=%b exp=0", inst_sram_req); end
    checks++; if (fs_to_ds_valid !== 1'b1 || fs_to_ds_bus !== 64'h1c00_0000_0280_0421) begin errors++; $display("FAIL stall_e0 got=%b/%h exp=1/1c000000_02800421", fs_to_ds_valid, fs_to_ds_bus); end
    for (int i = 0; i < 2; i++) begin
      tick();
      data_ok = 1'b0; rdata = 32'hdead_beef;
      #1;
      checks++; if (inst_sram_req !== 1'b0) begin errors++; $display("FAIL stall_hold_req%0d got=%b exp=0", i, inst_sram_req); end
      checks++; if (fs_to_ds_valid !== 1'b1 || fs_to_ds_bus !== 64'h1c00_0000_0280_0421) begin errors++; $display("FAIL stall_hold%0d got=%b/%h exp=1/1c000000_02800421", i, fs_to_ds_valid, fs_to_ds_bus); end
    end
    tick();
    ds_allowin = 1'b1;
    #1;
    checks++; if (fs_to_ds_valid !== 1'b1 || fs_to_ds_bus !== 64'h1c00_0000_0280_0421) begin errors++; $display("FAIL stall_release got=%b/%h exp=1/1c000000_02800421", fs_to_ds_valid, fs_to_ds_bus); end
    checks++; if (inst_sram_req !== 1'b1 || inst_sram_addr !== 32'h1c00_0004) begin errors++; $display("FAIL stall_resume_a got=%b/%h exp=1/1c000004", inst_sram_req, inst_sram_addr); end
    tick();
    addr_ok = 1'b0; data_ok = 1'b1; rdata = 32'h3333_0004;
    #1;
    checks++; if (fs_to_ds_valid !== 1'b1 || fs_to_ds_bus !== 64'h1c00_0004_3333_0004) begin errors++; $display("FAIL stall_next got=%b/%h exp=1/1c000004_33330004", fs_to_ds_valid, fs_to_ds_bus); end
  endtask

  task automatic test_branch_outstanding();
    do_reset();
    addr_ok = 1'b1;
    tick();
    addr_ok = 1'b0; br_bus = {1'b1, 32'h1c00_0100};
    #1;
    checks++; if (inst_sram_req !== 1'b0 || fs_to_ds_valid !== 1'b0) begin errors++; $display("FAIL bro_br got=%b/%b exp=0/0", inst_sram_req, fs_to_ds_valid); end
    tick();
    br_bus = '0;
    #1;
    checks++; if (inst_sram_req !== 1'b0) begin errors++; $display("FAIL bro_cancel_req got=%b exp=0", inst_sram_req); end
    tick();
    data_ok = 1'b1; rdata = 32'hbad0_bad0;
    #1;
    checks++; if (fs_to_ds_valid !== 1'b0 || inst_sram_req !== 1'b0) begin errors++; $display("FAIL bro_stale got=%b/%b exp=0/0", fs_to_ds_valid, inst_sram_req); end
    tick();
    data_ok = 1'b0; addr_ok = 1'b1;
    #1;
    checks++; if (inst_sram_req !== 1'b1 || inst_sram_addr !== 32'h1c00_0100) begin errors++; $display("FAIL bro_target got=%b/%h exp=1/1c000100", inst_sram_req, inst_sram_addr); end
    tick();
    addr_ok = 1'b0; data_ok = 1'b1; rdata = 32'h4444_0100;
    #1;
    checks++; if (fs_to_ds_valid !== 1'b1 || fs_to_ds_bus !== 64'h1c00_0100_4444_0100) begin errors++; $display("FAIL bro_entry got=%b/%h exp=1/1c000100_44440100", fs_to_ds_valid, fs_to_ds_bus); end
  endtask

  task automatic test_branch_handshake();
    do_reset();
    addr_ok = 1'b1;
    tick();
    data_ok = 1'b1; rdata = 32'h1111_0000;
    tick();
    data_ok = 1'b1; rdata = 32'h2222_0004; br_bus = {1'b1, 32'h1c00_0100};
    #1;
    checks++; if (inst_sram_req !== 1'b0) begin errors++; $display("FAIL brh_req got=%b exp=0", inst_sram_req); end
    checks++; if (fs_to_ds_valid !== 1'b0) begin errors++; $display("FAIL brh_valid got=%b exp=0", fs_to_ds_valid); end
    tick();
    br_bus = '0; data_ok = 1'b0;
    #1;
    checks++; if (inst_sram_req !== 1'b1 || inst_sram_addr !== 32'h1c00_0100) begin errors++; $display("FAIL brh_target got=%b/%h exp=1/1c000100", inst_sram_req, inst_sram_addr); end
    checks++; if (fs_to_ds_valid !== 1'b0) begin errors++; $display("FAIL brh_wrongpath got=%b exp=0", fs_to_ds_valid); end
    tick();
    addr_ok = 1'b0; data_ok = 1'b1; rdata = 32'h5555_0100;
    #1;
    checks++; if (fs_to_ds_valid !== 1'b1 || fs_to_ds_bus !== 64'h1c00_0100_5555_0100) begin errors++; $display("FAIL brh_entry got=%b/%h exp=1/1c000100_55550100", fs_to_ds_valid, fs_to_ds_bus); end
  endtask

  task automatic test_reset_midstream();
    do_reset();
    addr_ok = 1'b1;
    tick();
    data_ok = 1'b1; rdata = 32'h1111_0000;
    #1;
    checks++; if (fs_to_ds_valid !== 1'b1) begin errors++; $display("FAIL mrst_pre got=%b exp=1", fs_to_ds_valid); end
    tick();
    resetn = 1'b0; addr_ok = 1'b0; data_ok = 1'b0;
    #1;
    checks++; if (inst_sram_req !== 1'b0 || fs_to_ds_valid !== 1'b0 || fs_to_ds_bus !== 64'h0) begin errors++; $display("FAIL mrst_out got=%b/%b/%h exp=0/0/0", inst_sram_req, fs_to_ds_valid, fs_to_ds_bus); end
    tick();
    resetn = 1'b1;
    #1;
    checks++; if (inst_sram_req !== 1'b0) begin errors++; $display("FAIL mrst_release got=%b exp=0", inst_sram_req); end
    tick();
    #1;
    checks++; if (inst_sram_req !== 1'b1 || inst_sram_addr !== 32'h1c00_0000) begin errors++; $display("FAIL mrst_refetch got=%b/%h exp=1/1c000000", inst_sram_req, inst_sram_addr); end
  endtask

`ifdef IF_ADEF_CHECK_EN
  task automatic test_adef();
    do_reset();
    br_bus = {1'b1, 32'h1c00_0102};
    tick();
    br_bus = '0; addr_ok = 1'b1;
    #1;
    checks++; if (inst_sram_req !== 1'b0) begin errors++; $display("FAIL adef_req got=%b exp=0", inst_sram_req); end
    tick();
    #1;
    checks++; if (fs_to_ds_valid !== 1'b1 || fs_to_ds_bus !== 64'h1c00_0102_0000_0000) begin errors++; $display("FAIL adef_entry got=%b/%h exp=1/1c000102_00000000", fs_to_ds_valid, fs_to_ds_bus); end
    checks++; if (fs_adef !== 1'b1 || inst_sram_req !== 1'b0) begin errors++; $display("FAIL adef_flag got=%b/%b exp=1/0", fs_adef, inst_sram_req); end
  endtask
`endif

  initial begin
    test_reset();
    test_sequential();
    test_stall();
    test_branch_outstanding();
    test_branch_handshake();
    test_reset_midstream();
`ifdef IF_ADEF_CHECK_EN
    test_adef();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

endmodule
